// File: rtl/divider_8bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : divider_8bit_seq
// Description : Iterative restoring unsigned divider. Produces one quotient
//               bit per clock behind a start/busy/done handshake, so the
//               control unit can stall on DIV/MOD. Divide-by-zero completes
//               in a single cycle with a defined result and a flag.
// Ports       : clk         - system clock, rising edge
//               rst_n       - asynchronous active-low reset
//               start       - request a division (sampled only when idle)
//               dividend    - unsigned dividend, sampled at the accepting edge
//               divisor     - unsigned divisor, sampled at the accepting edge
//               busy        - iteration sequence in progress
//               done        - one-cycle pulse, results just updated
//               quotient    - registered quotient, held until next done
//               remainder   - registered remainder, held until next done
//               div_by_zero - registered flag for last completed operation
// Revision    : 1.0 - initial release
// ============================================================================
module divider_8bit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, w_a_next;          // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_d, w_d_next;          // latched divisor
  logic [WIDTH-1:0] r_p, w_p_next;          // partial remainder
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             w_done_next;
  logic [WIDTH-1:0] w_quotient_next;
  logic [WIDTH-1:0] w_remainder_next;
  logic             w_dbz_next;
  logic [WIDTH:0]   w_trial;

  // Trial subtraction of the divisor from the shifted partial remainder.
  // A set top bit means a borrow: the divisor does not fit this step.
  assign w_trial = {r_p, r_a[WIDTH-1]} - {1'b0, r_d};

  assign busy = (r_state == RUN);

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_a_next         = r_a;
    w_d_next         = r_d;
    w_p_next         = r_p;
    w_cnt_next       = r_cnt;
    w_done_next      = 1'b0;
    w_quotient_next  = quotient;
    w_remainder_next = remainder;
    w_dbz_next       = div_by_zero;

    case (r_state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // Defined result for x/0; no iterations are run.
            w_quotient_next  = '1;
            w_remainder_next = dividend;
            w_dbz_next       = 1'b1;
            w_done_next      = 1'b1;
          end else begin
            w_a_next     = dividend;
            w_d_next     = divisor;
            w_p_next     = '0;
            w_cnt_next   = '0;
            w_state_next = RUN;
          end
        end
      end

      RUN: begin
        if (!w_trial[WIDTH]) begin
          // A successful subtraction leaves a result below the divisor,
          // so its top bit is always zero and WIDTH bits suffice.
          w_p_next = w_trial[WIDTH-1:0];
          w_a_next = {r_a[WIDTH-2:0], 1'b1};
        end else begin
          // Restore path: the shifted value was below the divisor, hence
          // below 2**WIDTH, so dropping its top bit loses nothing.
          w_p_next = {r_p[WIDTH-2:0], r_a[WIDTH-1]};
          w_a_next = {r_a[WIDTH-2:0], 1'b0};
        end
        w_cnt_next = r_cnt + CNT_W'(1);

        if (r_cnt == LAST_STEP) begin
          w_quotient_next  = w_a_next;
          w_remainder_next = w_p_next;
          w_dbz_next       = 1'b0;
          w_done_next      = 1'b1;
          w_state_next     = IDLE;
        end
      end

      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_d         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_a         <= w_a_next;
      r_d         <= w_d_next;
      r_p         <= w_p_next;
      r_cnt       <= w_cnt_next;
      done        <= w_done_next;
      quotient    <= w_quotient_next;
      remainder   <= w_remainder_next;
      div_by_zero <= w_dbz_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_8bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_8bit_seq
// Description : Self-checking bench for divider_8bit_seq (WIDTH=8). A
//               transaction-level model (plain / and %, fixed latency)
//               is compared against the DUT every cycle; directed vectors
//               pin the results with hand-computed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_8bit_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  divider_8bit_seq #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transaction-level model: accept when idle, answer with / and % after
  // 8 clock edges, or immediately for a zero divisor.
  // --------------------------------------------------------------------------
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_q    = '0;
  logic [7:0] m_r    = '0;
  logic       m_z    = 1'b0;
  logic [7:0] p_q    = '0;
  logic [7:0] p_r    = '0;
  int         m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_z    <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_q    <= p_q;
          m_r    <= p_r;
          m_z    <= 1'b0;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start) begin
        if (divisor == 8'd0) begin
          m_done <= 1'b1;
          m_q    <= 8'hFF;
          m_r    <= dividend;
          m_z    <= 1'b1;
        end else begin
          m_busy <= 1'b1;
          m_left <= 8;
          p_q    <= dividend / divisor;
          p_r    <= dividend % divisor;
        end
      end
    end
  end

  // Cycle-by-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      check("cyc_done", {31'd0, done}, {31'd0, m_done});
      check("cyc_quotient", {24'd0, quotient}, {24'd0, m_q});
      check("cyc_remainder", {24'd0, remainder}, {24'd0, m_r});
      check("cyc_dbz", {31'd0, div_by_zero}, {31'd0, m_z});
    end
  end

  // Start one operation, wait (bounded) for done, pin the result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic ez, input int elat);
    int n;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("op_latency", n, elat);
    check("op_quotient", {24'd0, quotient}, {24'd0, eq});
    check("op_remainder", {24'd0, remainder}, {24'd0, er});
    check("op_dbz", {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    logic [7:0] cq;
    logic [7:0] cr;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", {24'd0, quotient}, 32'd0);
    check("rst_remainder", {24'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    run_op(8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 8);
    run_op(8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 8);
    run_op(8'd5,   8'd9,   8'd0,   8'd5, 1'b0, 8);
    run_op(8'd0,   8'd3,   8'd0,   8'd0, 1'b0, 8);
    run_op(8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 8);
    run_op(8'd200, 8'd0,   8'hFF,  8'd200, 1'b1, 0);
    run_op(8'd10,  8'd3,   8'd3,   8'd1, 1'b0, 8);
    run_op(8'd128, 8'd200, 8'd0,   8'd128, 1'b0, 8);

    // start re-asserted mid-run is ignored; exactly one done pulse
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; cq = '0; cr = '0;
    repeat (12) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        cq = quotient;
        cr = remainder;
      end
    end
    check("ign_pulses", pulses, 1);
    check("ign_quotient", {24'd0, cq}, 32'd14);
    check("ign_remainder", {24'd0, cr}, 32'd2);

    // back-to-back: start held through the done cycle
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    dividend = 8'd77; divisor = 8'd8;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_lat1", n, 8);
    check("b2b_q1", {24'd0, quotient}, 32'd14);
    check("b2b_r1", {24'd0, remainder}, 32'd2);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_held_q", {24'd0, quotient}, 32'd14);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_lat2", n, 8);
    check("b2b_q2", {24'd0, quotient}, 32'd9);
    check("b2b_r2", {24'd0, remainder}, 32'd5);

    // back-to-back divide-by-zero: done high on two consecutive cycles
    @(negedge clk);
    start = 1'b1; dividend = 8'd7; divisor = 8'd0;
    @(negedge clk);
    check("dz2_done1", {31'd0, done}, 32'd1);
    check("dz2_r1", {24'd0, remainder}, 32'd7);
    dividend = 8'd9;
    @(negedge clk);
    start = 1'b0;
    check("dz2_done2", {31'd0, done}, 32'd1);
    check("dz2_r2", {24'd0, remainder}, 32'd9);
    run_op(8'd77, 8'd8, 8'd9, 8'd5, 1'b0, 8);

    // asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_quotient", {24'd0, quotient}, 32'd0);
    check("arst_remainder", {24'd0, remainder}, 32'd0);
    check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("arst_no_done", pulses, 0);
    run_op(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 8);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/divider_8bit_seq.md
Name: divider_8bit_seq

Overview:
Iterative restoring unsigned divider. It is the inverse companion to the team's combinational 8-bit multiplier in the CPU-8Bit-Simplified datapath. It produces one quotient bit per clock and uses a start/busy/done handshake, so the control unit can stall on DIV/MOD instructions. Divide-by-zero is flagged and given a defined result.

Parameters:
WIDTH, 8, operand and result width in bits; legal values are WIDTH >= 2.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  reset; asynchronous, active-low
start  input  1  request a division; sampled only when busy=0
dividend  input  WIDTH  unsigned dividend; sampled at the accepting edge only
divisor  input  WIDTH  unsigned divisor; sampled at the accepting edge only
busy  output  1  high while an iteration sequence is in progress
done  output  1  single-cycle pulse: results valid and updated
quotient  output  WIDTH  registered quotient; held until the next done
remainder  output  WIDTH  registered remainder; held until the next done
div_by_zero  output  1  registered flag for the last completed operation

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values while rst_n=0: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE, iteration counter=0. Reset asserted mid-operation aborts immediately; no done is produced for the aborted operation.
- State machine: two states, IDLE and RUN.
- IDLE with start=1 and divisor!=0, at edge E0:
  - latch dividend into shift register A and divisor into D;
  - clear partial remainder P (WIDTH+1 bits);
  - set counter=0, go to RUN, set busy=1.
- IDLE with start=1 and divisor==0, at edge E0:
  - stay IDLE, busy stays 0;
  - quotient = all ones, remainder = dividend, div_by_zero=1, done=1 for the cycle after E0.
- RUN, one step per edge:
  - T = {P[WIDTH-1:0], A[WIDTH-1]} - {1'b0, D}, computed in WIDTH+1 bits.
  - If T[WIDTH]==0: P=T, A={A[WIDTH-2:0],1}.
  - Otherwise: P={P[WIDTH-1:0], A[WIDTH-1]}, A={A[WIDTH-2:0],0}.
  - Increment the counter.
- RUN completion: on the step where the counter reaches WIDTH-1, i.e. edge E_WIDTH:
  - quotient=final A, remainder=final P[WIDTH-1:0], div_by_zero=0;
  - done=1 for one cycle, busy=0, go to IDLE.
- Latency: done is high in the cycle after E_WIDTH (8 steps for WIDTH=8). busy is high from after E0 until E_WIDTH.
- done is deasserted on every other edge; it is never high for two consecutive cycles unless an operation completes on each edge. That can only happen with back-to-back divide-by-zero requests.
- start while busy=1 is ignored. dividend/divisor changes during RUN have no effect.
- Back-to-back: start=1 in the done cycle (busy=0) is accepted at that edge.
- quotient/remainder/div_by_zero change only at a completing edge; they are stable during RUN.
- Width rules: all arithmetic is unsigned; no signed mode. The counter is $clog2(WIDTH) bits wide.

Test Plan:
- 100/7: start for one cycle -> busy high 8 cycles; done pulse in the cycle after the 8th step edge; quotient=14, remainder=2, div_by_zero=0.
- Edge operands: 255/1 -> q=255, r=0; 5/9 -> q=0, r=5; 0/3 -> q=0, r=0; 255/255 -> q=1, r=0; all with 8-step latency.
- 200/0 -> done in the cycle right after the accepting edge, busy never high; q=8'hFF, r=200, div_by_zero=1. A following 10/3 clears the flag: q=3, r=1, div_by_zero=0.
- During 100/7, re-assert start with 50/5 at step 3 -> ignored; result is 14 r 2, and exactly one done pulse.
- Back-to-back: start=1 held through the done cycle of 100/7 with operands changed to 77/8 -> second operation accepted at the done edge; outputs 9 r 5 after 8 more steps; the first results are held until then.
- Pull rst_n low asynchronously at step 4 of 100/7 -> outputs zero immediately with no clock edge; no done pulse; a fresh 9/2 after release -> q=4, r=1.
